// File: rtl/program_loader_if.sv
// Boot-loader bus: byte stream in, instruction RAM write port and CPU-release status out.
// The loader takes the slave modport; the host/stream source takes the master modport.
interface program_loader_if #(
    parameter int ADDRESS_BUS_WIDTH = 10,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         start;
    logic [7:0]                   rx_data;
    logic                         rx_valid;
    logic                         rx_ready;
    logic                         imem_we;
    logic [ADDRESS_BUS_WIDTH-1:0] imem_addr;
    logic [INSTRUCTION_WIDTH-1:0] imem_wdata;
    logic                         cpu_reset;
    logic                         busy;
    logic                         done;
    logic                         error;
    logic [15:0]                  words_loaded;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, busy, done, error, words_loaded
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, busy, done, error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// Boot-stage loader: length-prefixed byte stream -> little-endian instruction words written from BASE_ADDR.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module program_loader #(
    parameter int ADDRESS_BUS_WIDTH = 10,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int BASE_ADDR         = 512,
    parameter int MAX_WORDS         = ((1 << ADDRESS_BUS_WIDTH) - BASE_ADDR) / (INSTRUCTION_WIDTH / 8)
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.slave bus
);
    localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / 8;
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [ADDRESS_BUS_WIDTH-1:0] BASE_A    = ADDRESS_BUS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] ADDR_STEP = ADDRESS_BUS_WIDTH'(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]             LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [15:0]                  MAX_LEN   = 16'(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LEN_LO = 4'd1,
        LEN_HI = 4'd2,
        DATA   = 4'd3,
        WRITE  = 4'd4,
        FINISH = 4'd5,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CKSUM  = 4'd6,
`endif
        DONE   = 4'd7,
        ERROR  = 4'd8
    } state_t;

    state_t                       state_r;
    logic [15:0]                  len_r;
    logic [IDX_W-1:0]             byte_idx_r;
    logic [ADDRESS_BUS_WIDTH-1:0] imem_addr_r;
    logic [INSTRUCTION_WIDTH-1:0] imem_wdata_r;
    logic                         rx_ready_r;
    logic                         imem_we_r;
    logic                         cpu_reset_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         error_r;
    logic [15:0]                  words_loaded_r;
    logic                         byte_accept_s;
    logic [15:0]                  len_full_s;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] cksum_r;

    function automatic logic [7:0] cksum_next(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

    assign byte_accept_s = bus.rx_valid && rx_ready_r;
    assign len_full_s    = {bus.rx_data, len_r[7:0]};

    assign bus.rx_ready     = rx_ready_r;
    assign bus.imem_we      = imem_we_r;
    assign bus.imem_addr    = imem_addr_r;
    assign bus.imem_wdata   = imem_wdata_r;
    assign bus.cpu_reset    = cpu_reset_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.error        = error_r;
    assign bus.words_loaded = words_loaded_r;

    // Load sequencer: state, stream handshake and every registered output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            len_r          <= 16'd0;
            byte_idx_r     <= {IDX_W{1'b0}};
            imem_addr_r    <= BASE_A;
            imem_wdata_r   <= {INSTRUCTION_WIDTH{1'b0}};
            rx_ready_r     <= 1'b0;
            imem_we_r      <= 1'b0;
            cpu_reset_r    <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            words_loaded_r <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            cksum_r        <= 8'd0;
`endif
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                IDLE, DONE, ERROR: begin
                    // start from any resting state re-arms a fresh load and re-holds the CPU
                    if (bus.start) begin
                        state_r        <= LEN_LO;
                        rx_ready_r     <= 1'b1;
                        busy_r         <= 1'b1;
                        done_r         <= 1'b0;
                        error_r        <= 1'b0;
                        cpu_reset_r    <= 1'b1;
                        words_loaded_r <= 16'd0;
                        imem_addr_r    <= BASE_A;
                        byte_idx_r     <= {IDX_W{1'b0}};
                        len_r          <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        cksum_r        <= 8'd0;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                LEN_LO: begin
                    if (byte_accept_s) begin
                        len_r   <= {8'd0, bus.rx_data};
                        state_r <= LEN_HI;
                    end else begin
                        state_r <= LEN_LO;
                    end
                end
                LEN_HI: begin
                    if (byte_accept_s) begin
                        len_r <= len_full_s;
                        if (len_full_s == 16'd0) begin
                            state_r    <= FINISH;
                            rx_ready_r <= 1'b0;
                        end else if (len_full_s > MAX_LEN) begin
                            state_r    <= ERROR;
                            rx_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            error_r    <= 1'b1;
                        end else begin
                            state_r    <= DATA;
                            byte_idx_r <= {IDX_W{1'b0}};
                        end
                    end else begin
                        state_r <= LEN_HI;
                    end
                end
                DATA: begin
                    if (byte_accept_s) begin
                        imem_wdata_r[{byte_idx_r, 3'b000} +: 8] <= bus.rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        cksum_r <= cksum_next(cksum_r, bus.rx_data);
`endif
                        if (byte_idx_r == LAST_IDX) begin
                            state_r    <= WRITE;
                            rx_ready_r <= 1'b0;
                            imem_we_r  <= 1'b1;
                            byte_idx_r <= {IDX_W{1'b0}};
                        end else begin
                            byte_idx_r <= byte_idx_r + IDX_W'(1);
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                WRITE: begin
                    imem_addr_r    <= imem_addr_r + ADDR_STEP;
                    words_loaded_r <= words_loaded_r + 16'd1;
                    if ((words_loaded_r + 16'd1) == len_r) begin
                        state_r <= FINISH;
                    end else begin
                        state_r    <= DATA;
                        rx_ready_r <= 1'b1;
                    end
                end
                FINISH: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_r    <= CKSUM;
                    rx_ready_r <= 1'b1;
`else
                    state_r     <= DONE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    cpu_reset_r <= 1'b0;
`endif
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CKSUM: begin
                    // a bad checksum leaves written words in RAM but keeps the CPU held
                    if (byte_accept_s) begin
                        rx_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        if (bus.rx_data == cksum_r) begin
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            cpu_reset_r <= 1'b0;
                        end else begin
                            state_r <= ERROR;
                            error_r <= 1'b1;
                        end
                    end else begin
                        state_r <= CKSUM;
                    end
                end
`endif
                default: begin
                    state_r     <= IDLE;
                    rx_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    cpu_reset_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the multicycle computer.
- Accepts a byte stream with a valid/ready handshake and assembles it into instruction words.
- Writes those words into instruction RAM starting at the reset address 0x200 (512), then releases the CPU from reset.
- While a load is in progress the CPU is held in reset.

Parameters:
- ADDRESS_BUS_WIDTH, 10, byte address width of instruction RAM.
- INSTRUCTION_WIDTH, 32, instruction word width; must be a multiple of 8.
- BASE_ADDR, 512, byte address of the first instruction written (matches the CPU reset address).
- MAX_WORDS, 128, maximum words accepted: (2^ADDRESS_BUS_WIDTH - BASE_ADDR) / (INSTRUCTION_WIDTH/8).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction RAM write strobe, one cycle per word.
- imem_addr  output  ADDRESS_BUS_WIDTH  instruction RAM byte address.
- imem_wdata  output  INSTRUCTION_WIDTH  assembled word.
- cpu_reset  output  1  reset to the CPU control unit.
- busy  output  1  a load is in progress.
- done  output  1  last load completed successfully.
- error  output  1  last load aborted.
- words_loaded  output  16  count of words written in the current or last load.

Behaviour:
- Reset (asynchronous) drives the following, from any state including mid-load:
  - state = IDLE; cpu_reset = 1.
  - rx_ready, imem_we, busy, done, error = 0.
  - imem_addr = BASE_ADDR; imem_wdata = 0; words_loaded = 0.
  - Internal length, byte index and word count are cleared.
- A byte is accepted only on a cycle where rx_valid && rx_ready.
- rx_ready = 1 only in LEN_LO, LEN_HI, DATA and CKSUM.
- States:
  - IDLE: cpu_reset is held at 1 until the first successful load. On start go to LEN_LO; set busy = 1, clear done, error and words_loaded, imem_addr = BASE_ADDR.
  - LEN_LO: accept byte -> len[7:0]; go to LEN_HI.
  - LEN_HI: accept byte -> len[15:8]. Then:
    - len == 0 -> FINISH.
    - len > MAX_WORDS -> ERROR, with no RAM write.
    - otherwise -> DATA.
  - DATA: bytes are packed little-endian; byte k goes to bits [8k+7:8k]. After byte INSTRUCTION_WIDTH/8 - 1 is accepted, go to WRITE.
  - WRITE (exactly one cycle):
    - imem_we = 1 with the current imem_addr and imem_wdata; rx_ready = 0.
    - Next cycle: imem_addr += INSTRUCTION_WIDTH/8 (mod 2^ADDRESS_BUS_WIDTH); words_loaded += 1.
    - Then go to FINISH if words_loaded+1 == len, else DATA.
  - FINISH: go to CKSUM if CHECKSUM_EN is defined, else DONE.
  - DONE: busy = 0, done = 1, cpu_reset = 0. Remains here until start, which re-enters LEN_LO with cpu_reset = 1 the following cycle.
  - ERROR: busy = 0, error = 1, cpu_reset = 1. Remains here until start, which behaves as from IDLE.
- Latency: imem_we rises in the cycle immediately after the final byte of a word is accepted. cpu_reset falls in the cycle after FINISH (or after CKSUM).
- start while busy is ignored.
- rx_valid with rx_ready = 0 leaves the byte unconsumed; the source must hold it.
- imem_we is never asserted outside WRITE.
- Address after the last possible word (1020 + 4) wraps to 0. This is unreachable given the MAX_WORDS check.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR is kept over every data byte (length bytes excluded).
  - CKSUM state accepts one trailing byte and compares it with the running XOR.
  - Match -> DONE. Mismatch -> ERROR; words already written remain in RAM, but cpu_reset stays 1.
- Undefined: no CKSUM state and no checksum logic; FINISH goes directly to DONE.

Test Plan:
- Reset mid-DATA (after 2 of 4 bytes): all outputs return to their reset values. A new start plus a full stream loads correctly from 0x200.
- start, then bytes 02 00 | 13 00 00 00 | 37 12 00 00 with rx_valid always high:
  - Two imem_we pulses: addr 512 data 0x00000013, then addr 516 data 0x00001237.
  - words_loaded = 2, done = 1, cpu_reset = 0.
- Length 00 00: no imem_we; done = 1 and cpu_reset = 0 within 2 cycles after LEN_HI.
- Length 0x0081 (129): error = 1, cpu_reset = 1, zero writes. A subsequent start plus a valid stream clears error.
- rx_valid toggling every other cycle, plus a start pulse during DATA: same writes as the two-word test, start ignored. rx_ready is low in the WRITE cycle.
- With PROGRAM_LOADER_CHECKSUM_EN, one word 13 00 00 00:
  - Checksum 0x13 -> done = 1.
  - Checksum 0x12 -> error = 1, cpu_reset = 1, the word at 512 is still written.
